// File: rtl/latch_if_id_queue.sv
// IF/ID decoupling queue: FWFT circular buffer between fetch and decode with
// bubble output when empty. Optional stall statistics under LATCH_IF_ID_QUEUE_STATS_EN.
module latch_if_id_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic [DATA_WIDTH-1:0] if_instruction,
  output logic                  if_ready,
  input  logic                  id_stall,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_instruction,
  output logic [CW-1:0]         count
`ifdef LATCH_IF_ID_QUEUE_STATS_EN
  ,
  output logic [15:0]           full_stall_count
`endif
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            enq, deq;
  entry_t          head;

  // Handshakes depend only on registered occupancy, never on id_stall.
  assign if_ready = (count_q < DEPTH_C);
  assign id_valid = (count_q != '0);
  assign enq      = if_valid && if_ready && !flush && !reset;
  assign deq      = id_valid && !id_stall && !flush && !reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (reset || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= '{pc: if_pc, instr: if_instruction};
  end

  assign head           = mem_q[rd_ptr_q];
  assign id_pc          = id_valid ? head.pc    : '0;
  assign id_instruction = id_valid ? head.instr : '0;
  assign count          = count_q;

`ifdef LATCH_IF_ID_QUEUE_STATS_EN
  logic [15:0] fs_cnt_q, fs_cnt_d;

  // Saturating count of fetch-blocked cycles; flush does not clear it.
  always_comb begin
    fs_cnt_d = fs_cnt_q;
    if (if_valid && !if_ready && (fs_cnt_q != 16'hFFFF))
      fs_cnt_d = fs_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) fs_cnt_q <= '0;
    else       fs_cnt_q <= fs_cnt_d;
  end

  assign full_stall_count = fs_cnt_q;
`endif

endmodule

// File: tb/tb_latch_if_id_queue.sv
// Self-checking bench for latch_if_id_queue: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_latch_if_id_queue;
  localparam int DW = 32, AW = 32, DEPTH = 4, CW = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset, flush, if_valid, id_stall;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_instruction;
  logic          if_ready, id_valid;
  logic [AW-1:0] id_pc;
  logic [DW-1:0] id_instruction;
  logic [CW-1:0] count;
`ifdef LATCH_IF_ID_QUEUE_STATS_EN
  logic [15:0]   full_stall_count;
`endif

  latch_if_id_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
    .if_ready(if_ready), .id_stall(id_stall), .id_valid(id_valid),
    .id_pc(id_pc), .id_instruction(id_instruction), .count(count)
`ifdef LATCH_IF_ID_QUEUE_STATS_EN
    , .full_stall_count(full_stall_count)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;

  // Reference model: plain FIFO of (pc, instr) pairs.
  bit [AW-1:0] m_pc[$];
  bit [DW-1:0] m_in[$];
  int          m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit [AW-1:0] pc, input bit [DW-1:0] ins,
                       input bit st, input bit fl, input bit rs);
    if_valid = v; if_pc = pc; if_instruction = ins;
    id_stall = st; flush = fl; reset = rs;
  endtask

  // Advance one clock; model decides from the pre-edge inputs, outputs checked at negedge.
  task automatic cycle();
    bit full, do_push, do_pop;
    bit [AW-1:0] pc; bit [DW-1:0] ins;
    full    = (m_pc.size() == DEPTH);
    do_push = if_valid && !full;
    do_pop  = (m_pc.size() > 0) && !id_stall;
    pc = if_pc; ins = if_instruction;
    if (reset) m_stall = 0;
    else if (if_valid && full && m_stall < 16'hFFFF) m_stall++;
    @(posedge clock);
    if (reset || flush) begin
      m_pc.delete(); m_in.delete();
    end else begin
      if (do_pop)  begin void'(m_pc.pop_front()); void'(m_in.pop_front()); end
      if (do_push) begin m_pc.push_back(pc); m_in.push_back(ins); end
    end
    @(negedge clock);
    check_all();
  endtask

  task automatic check_all();
    bit e_v;
    e_v = (m_pc.size() > 0);
    chk("count",    64'(count),    64'(m_pc.size()));
    chk("if_ready", 64'(if_ready), 64'(m_pc.size() < DEPTH));
    chk("id_valid", 64'(id_valid), 64'(e_v));
    chk("id_pc",    64'(id_pc),    e_v ? 64'(m_pc[0]) : 64'd0);
    chk("id_instr", 64'(id_instruction), e_v ? 64'(m_in[0]) : 64'd0);
`ifdef LATCH_IF_ID_QUEUE_STATS_EN
    chk("fs_count", 64'(full_stall_count), 64'(m_stall));
`endif
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, AW'(32'h2000 + 4*i), $urandom, 1, 0, 0); cycle();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clock);
    do_reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(if_ready), 64'd1);
    chk("rst_valid", 64'(id_valid), 64'd0);

    // Single entry flows through with one cycle latency, then bubble.
    drive(1, 32'h100, 32'h2408000A, 0, 0, 0); cycle();
    chk("fwft_valid", 64'(id_valid), 64'd1);
    chk("fwft_pc",    64'(id_pc), 64'h100);
    chk("fwft_instr", 64'(id_instruction), 64'h2408000A);
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("bubble_count", 64'(count), 64'd0);
    chk("bubble_pc",    64'(id_pc), 64'd0);

    // Overfill while stalled; fifth entry must be dropped.
    for (int i = 0; i < 5; i++) begin
      drive(1, AW'(4*i), AW'(32'hA000 + i), 1, 0, 0); cycle();
      if (i == 3) chk("full_ready", 64'(if_ready), 64'd0);
    end
    chk("full_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(id_pc), 64'(4*i));
      drive(0, 0, 0, 0, 0, 0); cycle();
    end
    chk("drain_empty", 64'(id_valid), 64'd0);

    // Steady push+pop at count=2 wraps pointers without reordering.
    fill(2);
    for (int i = 0; i < 10; i++) begin
      drive(1, AW'(32'h3000 + 4*i), $urandom, 0, 0, 0); cycle();
      chk("pp_count", 64'(count), 64'd2);
    end
    chk("pp_head", 64'(id_pc), 64'h3020);

    // Flush beats the concurrent fetch.
    do_reset(); fill(3);
    drive(1, 32'hDEAD, 32'hBEEF, 0, 1, 0); cycle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(id_valid), 64'd0);
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("flush_drop", 64'(id_valid), 64'd0);

    // Reset mid-operation.
    fill(3);
    drive(1, 32'h44, 32'h55, 0, 1, 1); cycle();
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_pc",    64'(id_pc), 64'd0);
    chk("mrst_ready", 64'(if_ready), 64'd1);
    drive(0, 0, 0, 0, 0, 0);

`ifdef LATCH_IF_ID_QUEUE_STATS_EN
    do_reset(); fill(4);
    for (int i = 0; i < 7; i++) begin
      drive(1, 32'h77, 0, 1, 0, 0); cycle();
    end
    chk("stat7", 64'(full_stall_count), 64'd7);
    drive(0, 0, 0, 0, 1, 0); cycle();
    chk("stat_flush", 64'(full_stall_count), 64'd7);
`endif

    // Random traffic with occasional flush/reset.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 60) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/latch_if_id_queue.md
LATCH_IF_ID_QUEUE -- requirements
Module: latch_if_id_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: PC width.
REQ-003 SHALL have parameter DEPTH, default 4: number of buffered fetch entries; legal values are powers of two from 2 to 16.
REQ-004 SHALL have port clock, input, 1: clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1: discard all buffered entries (branch or exception redirect).
REQ-007 SHALL have port if_valid, input, 1: fetch stage presents an entry.
REQ-008 SHALL have port if_pc, input, ADDR_WIDTH: PC of the presented entry.
REQ-009 SHALL have port if_instruction, input, DATA_WIDTH: presented instruction.
REQ-010 SHALL have port if_ready, output, 1: buffer can accept an entry this cycle.
REQ-011 SHALL have port id_stall, input, 1: decode cannot consume the head this cycle.
REQ-012 SHALL have port id_valid, output, 1: head entry is valid.
REQ-013 SHALL have port id_pc, output, ADDR_WIDTH: PC of the head entry.
REQ-014 SHALL have port id_instruction, output, DATA_WIDTH: head instruction.
REQ-015 SHALL have port count, output, clog2(DEPTH)+1: number of occupied entries.

Function
REQ-016 SHALL enqueue at the rising edge when if_valid=1, if_ready=1 and flush=0.
REQ-017 SHALL dequeue at the rising edge when id_valid=1, id_stall=0 and flush=0.
REQ-018 SHALL drive if_ready = (count < DEPTH), decoded from registered count only, with no combinational path from id_stall.
REQ-019 SHALL present the head entry first-word-fall-through: an entry enqueued into an empty buffer at edge N appears on id_* in the cycle after edge N.
REQ-020 SHALL drive id_valid=0, id_pc=0 and id_instruction=0 (bubble, NOP) whenever count=0.
REQ-021 SHALL, on a simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
REQ-022 SHALL wrap read and write pointers modulo DEPTH.
REQ-023 SHALL ignore if_valid while full, with no overwrite and no error.
REQ-024 SHALL ignore a dequeue request while empty, and count SHALL never underflow.
REQ-025 SHALL give flush priority over simultaneous enqueue and dequeue: at the edge, count=0 and pointers=0, so id_* show the bubble in the next cycle and the concurrent if_* entry is dropped.
REQ-026 SHALL keep id_* stable while id_stall=1 and id_valid=1.

Reset
REQ-027 SHALL, at a rising edge with reset=1, set count=0, both pointers=0, id_valid=0, id_pc=0 and id_instruction=0, overriding flush and all handshakes.
REQ-028 SHALL drive if_ready=1 in the first cycle after reset.
REQ-029 SHALL discard all buffered entries when reset is asserted mid-operation; buffer storage contents need not be cleared.

Configuration
REQ-030 SHALL, when macro LATCH_IF_ID_QUEUE_STATS_EN is defined, add output port full_stall_count, 16 bits: number of cycles with if_valid=1 and if_ready=0, saturating at 16'hFFFF, cleared by reset only (not by flush).
REQ-031 SHALL, without LATCH_IF_ID_QUEUE_STATS_EN, omit the full_stall_count port and its counter entirely, leaving all other behaviour identical.

Verification
REQ-032 SHALL cover: reset, then if_valid=1 with pc=0x100 and instr=0x2408000A for one cycle, id_stall=0 -> next cycle id_valid=1, id_pc=0x100; one cycle later bubble with count=0.
REQ-033 SHALL cover: DEPTH=4, id_stall=1, push 5 entries (pc 0x0,0x4,0x8,0xC,0x10) -> if_ready=0 after the 4th; 0x10 is not accepted; releasing the stall drains 0x0, 0x4, 0x8, 0xC in order.
REQ-034 SHALL cover: count=2, then simultaneous push and pop for 10 cycles -> count stays 2, pointers wrap, order is preserved.
REQ-035 SHALL cover: count=3 with flush=1 and if_valid=1 in the same cycle -> next cycle count=0 and id_valid=0; the flushing-cycle entry never appears.
REQ-036 SHALL cover: count=3, reset pulse for one cycle -> count=0, id_*=0, if_ready=1.
REQ-037 SHALL cover, with LATCH_IF_ID_QUEUE_STATS_EN: buffer full with if_valid=1 for 7 cycles -> full_stall_count=7; a flush leaves it at 7.
